note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Upstream feeder of the note timer in the music player. Walks the song ROM one note per entry,
//  issues each note with its duration, then waits for the timer's end-of-note flag before advancing.
//  Its outputs drive the timer's update_note_length/note_length. note_done comes from note_did_end.
// PARAMETERS
//  NOTE_W       6  note-code width; code 0 = rest
//  DUR_W        6  duration width; must equal the timer's note_length width
//  SONG_BITS    2  song select width (4 songs)
//  INDEX_BITS   5  note-index width (32 entries per song)
//  ROM_LATENCY  1  cycles from rom_addr change to valid rom_data (>=1)
// PORTS
//  clk        in   1                    system clock
//  reset      in   1                    asynchronous, active-high
//  play       in   1                    level: 1 = run, 0 = pause
//  restart    in   1                    sync pulse: abort song, return to IDLE
//  song       in   SONG_BITS            song select; sampled only on IDLE->FETCH
//  note_done  in   1                    end-of-note flag from note timer
//  rom_addr   out  SONG_BITS+INDEX_BITS {song_q, index_q}
//  rom_data   in   NOTE_W+DUR_W         {note, duration}; note in MSBs
//  new_note   out  1                    1-cycle pulse: note/duration valid, load timer
//  note       out  NOTE_W               registered note code
//  duration   out  DUR_W                registered duration
//  song_done  out  1                    1-cycle pulse at end of song
//  busy       out  1                    1 in any state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; song_q, index_q, note, duration, wait count = 0; all pulses 0.
//  States: IDLE, FETCH, DECODE, ISSUE, WAIT.
//  IDLE:   play=1 -> latch song into song_q, set index_q=0, go to FETCH.
//  FETCH:  hold rom_addr for ROM_LATENCY cycles (down-counter), then go to DECODE.
//  DECODE: rom_data is valid.
//          rom_data==0 (end marker) -> song_done=1 next cycle, go to IDLE.
//          Otherwise register note/duration, go to ISSUE.
//  ISSUE:  new_note=1 for exactly this cycle, then go to WAIT.
//  WAIT:   note_done & play -> advance the note.
//          note_done & ~play -> hold in WAIT (paused).
//  Advance: if index_q==2^INDEX_BITS-1 -> song_done pulse, go to IDLE.
//           Else index_q+1, go to FETCH.
//  Latency: play sampled in IDLE at cycle t -> new_note at t+ROM_LATENCY+2.
//  Timer interaction: in the WAIT entry cycle the timer already holds duration.
//   duration!=0: note_done is low until the count expires.
//   duration==0: note_done is high at once. The note lasts 1 cycle and sequencing proceeds.
//  play=0 in FETCH/DECODE/ISSUE: those states still complete. Only WAIT and IDLE gate on play.
//  restart: highest priority over note_done/play. Next state=IDLE, index_q=0.
//   Suppresses new_note and song_done on that cycle. note/duration keep their last values.
//  song changes while busy: ignored until the next IDLE->FETCH.
//  index_q wraps only via song end; it never wraps silently past the last entry.
//  new_note and song_done are never high on the same cycle.
//  Reset mid-song: immediate return to IDLE. The timer is reset by the same signal.
// STRUCTURE
//  Shared header music_defs.vh:
//   - state encodings (3-bit)
//   - SEQ_END_MARKER
//   - note/duration widths shared with the note timer
//  One flat module, no sub-module. All state is in dffr-style registers with async reset.
//  Next-state logic is in one combinational always block. The song ROM stays external.
// TESTING
//  1. Reset, play=1, song=2, ROM {5,3},{7,2},end -> rom_addr 64,65,66.
//     new_note with (5,3) then (7,2), then song_done. busy=0 after.
//  2. ROM_LATENCY=1, play rises at t -> new_note exactly at t+3.
//     new_note is one cycle wide. duration=3 matches the timer load.
//  3. play=0 during WAIT with note_done=1 -> no advance.
//     play=1 again -> FETCH of index+1 next cycle.
//  4. All 32 entries non-zero -> song_done after entry 31, index_q back to 0.
//     No fetch at index 32; the address never leaves the song.
//  5. restart and note_done in the same cycle of WAIT -> IDLE, no new_note, no song_done.
//     song input changed mid-song is latched only on the next start.
//  6. Async reset asserted mid-FETCH with clk stopped -> outputs 0 and state IDLE immediately.
//     Entry with duration=0 -> WAIT lasts 1 cycle.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared widths, state encoding and ROM-word helpers for the song sequencer.
// The note and duration widths match the note timer that consumes them.
package note_sequencer_pkg;

    localparam int NOTE_W          = 6;
    localparam int DUR_W           = 6;
    localparam int SONG_BITS       = 2;
    localparam int INDEX_BITS      = 5;
    localparam int DEF_ROM_LATENCY = 1;
    localparam int ADDR_W          = SONG_BITS + INDEX_BITS;
    localparam int DATA_W          = NOTE_W + DUR_W;

    localparam logic [DATA_W-1:0]     SEQ_END_MARKER = {DATA_W{1'b0}};
    localparam logic [INDEX_BITS-1:0] LAST_INDEX     = {INDEX_BITS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4
    } seq_state_e;

    function automatic logic is_end_marker(input logic [DATA_W-1:0] word);
        return (word == SEQ_END_MARKER);
    endfunction

    function automatic logic [NOTE_W-1:0] word_note(input logic [DATA_W-1:0] word);
        return word[DATA_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_duration(input logic [DATA_W-1:0] word);
        return word[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/note_sequencer.sv
// Walks one song of the external ROM, issuing each {note, duration} to the note timer
// and waiting for its end-of-note flag before fetching the next entry.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  restart,
    input  logic [SONG_BITS-1:0]  song,
    input  logic                  note_done,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  new_note,
    output logic [NOTE_W-1:0]     note,
    output logic [DUR_W-1:0]      duration,
    output logic                  song_done,
    output logic                  busy
);

    localparam int              LAT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ROM_LATENCY - 1);

    seq_state_e              state_q, state_d;
    logic [SONG_BITS-1:0]    song_q, song_d;
    logic [INDEX_BITS-1:0]   index_q, index_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [NOTE_W-1:0]       note_q, note_d;
    logic [DUR_W-1:0]        duration_q, duration_d;
    logic                    new_note_q, new_note_d;
    logic                    song_done_q, song_done_d;
    logic                    busy_q, busy_d;

    // Restart overrides everything; pulses are only ever raised on the transition into ISSUE/IDLE.
    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        index_d     = index_q;
        lat_d       = lat_q;
        note_d      = note_q;
        duration_d  = duration_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        if (restart) begin
            state_d = ST_IDLE;
            index_d = {INDEX_BITS{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_FETCH;
                        song_d  = song;
                        index_d = {INDEX_BITS{1'b0}};
                        lat_d   = LAT_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (lat_q == {LAT_W{1'b0}}) begin
                        state_d = ST_DECODE;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (is_end_marker(rom_data)) begin
                        state_d     = ST_IDLE;
                        index_d     = {INDEX_BITS{1'b0}};
                        song_done_d = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        note_d     = word_note(rom_data);
                        duration_d = word_duration(rom_data);
                        new_note_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // A last-slot note ends the song instead of wrapping the index.
                    if (note_done && play) begin
                        if (index_q == LAST_INDEX) begin
                            state_d     = ST_IDLE;
                            index_d     = {INDEX_BITS{1'b0}};
                            song_done_d = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                            index_d = index_q + INDEX_BITS'(1);
                            lat_d   = LAT_INIT;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = {INDEX_BITS{1'b0}};
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            song_q      <= {SONG_BITS{1'b0}};
            index_q     <= {INDEX_BITS{1'b0}};
            lat_q       <= {LAT_W{1'b0}};
            note_q      <= {NOTE_W{1'b0}};
            duration_q  <= {DUR_W{1'b0}};
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            index_q     <= index_d;
            lat_q       <= lat_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_addr  = {song_q, index_q};
    assign new_note  = new_note_q;
    assign note      = note_q;
    assign duration  = duration_q;
    assign song_done = song_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a song-level model predicts every new_note/song_done
// event (content, ROM address and, when play is held steady, the exact cycle).
module tb_note_sequencer;
    import note_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 clk_en = 1'b1;
    logic                 reset = 1'b1;
    logic                 play = 1'b0;
    logic                 restart = 1'b0;
    logic [SONG_BITS-1:0] song_in = '0;
    logic                 note_done;
    logic [ADDR_W-1:0]    rom_addr;
    logic [DATA_W-1:0]    rom_data;
    logic                 new_note;
    logic [NOTE_W-1:0]    note;
    logic [DUR_W-1:0]     duration;
    logic                 song_done;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_cnt = 0;

    logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

    typedef struct {
        bit                done;
        logic [NOTE_W-1:0] nt;
        logic [DUR_W-1:0]  du;
        logic [ADDR_W-1:0] addr;
        int                at;
    } exp_t;
    exp_t exp_q[$];

    note_sequencer dut (
        .clk(clk), .reset(reset), .play(play), .restart(restart), .song(song_in),
        .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
        .new_note(new_note), .note(note), .duration(duration),
        .song_done(song_done), .busy(busy)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Song ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Note timer: loads duration on new_note, flags end when the count is zero.
    always @(posedge clk or posedge reset) begin
        if (reset) t_cnt <= 0;
        else if (new_note) t_cnt <= int'(duration);
        else if (t_cnt != 0) t_cnt <= t_cnt - 1;
    end
    assign note_done = (t_cnt == 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (new_note || song_done)) begin
            chk("pulse_exclusive", 32'(new_note & song_done), 32'd0);
            chk("event_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("event_kind_song_done", 32'(song_done), 32'(e.done));
                if (!e.done) begin
                    chk("note", 32'(note), 32'(e.nt));
                    chk("duration", 32'(duration), 32'(e.du));
                end
                chk("event_rom_addr", 32'(rom_addr), 32'(e.addr));
                if (e.at >= 0) chk("event_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Song-level model: notes in ROM order until the end marker or the 32nd entry.
    // Without pauses, a note of duration d is followed by the next event d+4 cycles
    // later (d+2 after the final slot, which skips the fetch of a marker).
    function automatic void build_exp(input int s, input int t0, input bit timed);
        int t;
        exp_t e;
        logic [DATA_W-1:0] w;
        t = t0 + 3;
        for (int i = 0; i < 32; i++) begin
            w = rom_mem[s*32 + i];
            if (w == '0) begin
                e.done = 1'b1; e.nt = '0; e.du = '0;
                e.addr = ADDR_W'(s*32); e.at = timed ? t : -1;
                exp_q.push_back(e);
                return;
            end
            e.done = 1'b0; e.nt = w[DATA_W-1:DUR_W]; e.du = w[DUR_W-1:0];
            e.addr = ADDR_W'(s*32 + i); e.at = timed ? t : -1;
            exp_q.push_back(e);
            t = t + int'(w[DUR_W-1:0]) + ((i == 31) ? 2 : 4);
        end
        e.done = 1'b1; e.nt = '0; e.du = '0;
        e.addr = ADDR_W'(s*32); e.at = timed ? t : -1;
        exp_q.push_back(e);
    endfunction

    task automatic fill_song(input int s, input bit full);
        int end_at;
        end_at = full ? 32 : $urandom_range(0, 10);
        for (int i = 0; i < 32; i++) begin
            if (i == end_at) rom_mem[s*32 + i] = '0;
            else rom_mem[s*32 + i] = {NOTE_W'($urandom_range(1, 63)), DUR_W'($urandom_range(0, 4))};
        end
    endtask

    task automatic finish_song(input bit pauses);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(posedge clk); #1;
            if (song_done) seen = 1'b1;
            else if (n >= 3) begin
                if (pauses) play = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) song_in = SONG_BITS'($urandom);
            end
        end
        play = 1'b0;
        chk("song_completed", 32'(seen), 32'd1);
        @(posedge clk); #1;
        chk("busy_after_song", 32'(busy), 32'd0);
        chk("all_events_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_song(input int s, input bit pauses);
        build_exp(s, cyc, !pauses);
        song_in = SONG_BITS'(s);
        play = 1'b1;
        finish_song(pauses);
    endtask

    task automatic wait_new_note(input string nm);
        for (int n = 0; n < 40 && !new_note; n++) begin
            @(posedge clk); #1;
        end
        chk(nm, 32'(new_note), 32'd1);
    endtask

    initial begin
        exp_t e;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = '0;

        repeat (3) @(posedge clk); #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_new_note", 32'(new_note), 32'd0);
        chk("reset_song_done", 32'(song_done), 32'd0);
        chk("reset_note", 32'(note), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-note song 2, exact timing.
        rom_mem[64] = {6'd5, 6'd3};
        rom_mem[65] = {6'd7, 6'd2};
        rom_mem[66] = '0;
        run_song(2, 1'b0);

        // Pause in WAIT after the timer expires, then resume.
        rom_mem[32] = {6'd9, 6'd6};
        rom_mem[33] = {6'd10, 6'd1};
        rom_mem[34] = '0;
        build_exp(1, cyc, 1'b0);
        song_in = 2'd1;
        play = 1'b1;
        wait_new_note("pause_first_note");
        a = rom_addr;
        play = 1'b0;
        repeat (12) @(posedge clk); #1;
        chk("paused_note_done", 32'(note_done), 32'd1);
        chk("paused_busy", 32'(busy), 32'd1);
        chk("paused_addr", 32'(rom_addr), 32'(a));
        play = 1'b1;
        @(posedge clk); #1;
        chk("resume_addr", 32'(rom_addr), 32'(a + ADDR_W'(1)));
        finish_song(1'b0);

        // Restart in a WAIT cycle where note_done is already high.
        rom_mem[96] = {6'd4, 6'd0};
        rom_mem[97] = {6'd6, 6'd2};
        rom_mem[98] = '0;
        e.done = 1'b0; e.nt = 6'd4; e.du = 6'd0; e.addr = 7'd96; e.at = cyc + 3;
        exp_q.push_back(e);
        song_in = 2'd3;
        play = 1'b1;
        wait_new_note("restart_first_note");
        @(posedge clk); #1;
        chk("restart_note_done", 32'(note_done), 32'd1);
        restart = 1'b1;
        play = 1'b0;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("restart_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk); #1;
        chk("restart_stays_idle", 32'(busy), 32'd0);
        chk("restart_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_song(3, 1'b0);

        // Randomised songs, alternating steady play and random pauses.
        for (int r = 0; r < 10; r++) begin
            int s;
            s = $urandom_range(0, 3);
            fill_song(s, (r == 3) || (r == 6));
            run_song(s, r[0]);
        end

        // Async reset mid-FETCH with the clock stopped.
        fill_song(2, 1'b0);
        rom_mem[64] = {6'd11, 6'd1};
        song_in = 2'd2;
        play = 1'b1;
        @(posedge clk); #1;
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_addr", 32'(rom_addr), 32'd64);
        clk_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_addr", 32'(rom_addr), 32'd0);
        chk("async_note", 32'(note), 32'd0);
        chk("async_duration", 32'(duration), 32'd0);
        chk("async_new_note", 32'(new_note), 32'd0);
        play = 1'b0;
        #2;
        reset = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_song(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
